// File: rtl/ebi_pkg.sv
// Shared types, defaults and helpers for the EBI virtual-channel transmitter.
package ebi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } ebi_vc_state_e;

    localparam int unsigned EBI_CHANNEL_LENGTH_LIST [4] = '{64, 40, 24, 16};

    // Number of link beats needed to carry len bits over a width-bit bus.
    function automatic int unsigned beats(input int unsigned len, input int unsigned width);
        return (len + width - 1) / width;
    endfunction

endpackage

// File: rtl/ebi_rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last granted one.
module ebi_rr_arbiter #(
    parameter  int CHANNEL_NUM = 4,
    localparam int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNEL_NUM-1:0] req,
    input  logic                   advance,
    output logic                   gnt_vld,
    output logic [IDX_W-1:0]       gnt_idx
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= CHANNEL_NUM; i++) begin
            cand = IDX_W'((int'(last_q) + i) % CHANNEL_NUM);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Pointer parks on the last channel so channel 0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(CHANNEL_NUM - 1);
        end else if (advance) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/ebi_vc_tx.sv
// Credit-based multi-VC transmitter: arbitrates VCs, then sends a header beat
// followed by the message LSB-first over a narrow link.
module ebi_vc_tx
    import ebi_pkg::*;
#(
    parameter int          CHANNEL_NUM        = 4,
    parameter int          CHANNEL_NUM_WIDTH  = 2,
    parameter int          MAX_MESSAGE_LENGTH = 64,
    parameter int          BUS_WIDTH          = 8,
    parameter int          CREDIT_DEPTH       = 2,
    parameter int unsigned CHANNEL_LENGTH_LIST [CHANNEL_NUM] = EBI_CHANNEL_LENGTH_LIST
) (
    input  logic                          bus_clk,
    input  logic                          rst_n,
    input  logic [MAX_MESSAGE_LENGTH-1:0] channel_hs_entry_i [CHANNEL_NUM],
    input  logic [CHANNEL_NUM-1:0]        channel_entry_valid_i,
    output logic [CHANNEL_NUM-1:0]        channel_push_ready_o,
    output logic                          bus_valid_o,
    output logic [BUS_WIDTH-1:0]          bus_data_o,
    input  logic                          credit_valid_i,
    input  logic [CHANNEL_NUM_WIDTH-1:0]  credit_vc_i,
    output logic                          credit_err_o,
    output logic                          busy_o
);

    localparam int MAX_BEATS = beats(MAX_MESSAGE_LENGTH, BUS_WIDTH);
    localparam int SHR_W     = MAX_BEATS * BUS_WIDTH;
    localparam int BCNT_W    = $clog2(MAX_BEATS + 1);

    ebi_vc_state_e                 state_q, state_d;
    logic [SHR_W-1:0]              shreg_q;
    logic [BCNT_W-1:0]             beat_cnt_q;
    logic [CHANNEL_NUM_WIDTH-1:0]  cur_vc_q;
    logic [3:0]                    credit_q [CHANNEL_NUM];
    logic [3:0]                    credit_d [CHANNEL_NUM];
    logic                          credit_err_q;
    logic                          credit_bad;
    logic [CHANNEL_NUM-1:0]        elig, take, give;
    logic                          arb_vld;
    logic [CHANNEL_NUM_WIDTH-1:0]  arb_idx;
    logic                          grant;
    logic [MAX_MESSAGE_LENGTH-1:0] len_mask [CHANNEL_NUM];

    for (genvar v = 0; v < CHANNEL_NUM; v++) begin : g_vc
        assign elig[v]     = channel_entry_valid_i[v] && (credit_q[v] != 4'd0);
        assign len_mask[v] = {MAX_MESSAGE_LENGTH{1'b1}} >> (MAX_MESSAGE_LENGTH - CHANNEL_LENGTH_LIST[v]);
    end

    ebi_rr_arbiter #(
        .CHANNEL_NUM(CHANNEL_NUM)
    ) u_arb (
        .clk    (bus_clk),
        .rst_n  (rst_n),
        .req    (elig),
        .advance(grant),
        .gnt_vld(arb_vld),
        .gnt_idx(arb_idx)
    );

    // rst_n gating keeps the combinational ready low while reset is held.
    assign grant        = rst_n && (state_q == IDLE) && arb_vld;
    assign busy_o       = (state_q != IDLE);
    assign credit_err_o = credit_err_q;

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        channel_push_ready_o = '0;
        bus_valid_o          = 1'b0;
        bus_data_o           = '0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    channel_push_ready_o[arb_idx] = 1'b1;
                    state_d                       = HEADER;
                end
            end
            HEADER: begin
                bus_valid_o = 1'b1;
                bus_data_o  = BUS_WIDTH'(cur_vc_q);
                state_d     = PAYLOAD;
            end
            PAYLOAD: begin
                bus_valid_o = 1'b1;
                bus_data_o  = shreg_q[BUS_WIDTH-1:0];
                if (beat_cnt_q <= BCNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry is masked at capture so padding beats above the length are zero.
    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            beat_cnt_q <= '0;
            cur_vc_q   <= '0;
        end else if (grant) begin
            shreg_q    <= SHR_W'(channel_hs_entry_i[arb_idx] & len_mask[arb_idx]);
            beat_cnt_q <= BCNT_W'(beats(CHANNEL_LENGTH_LIST[arb_idx], BUS_WIDTH));
            cur_vc_q   <= arb_idx;
        end else if (state_q == PAYLOAD) begin
            shreg_q    <= shreg_q >> BUS_WIDTH;
            beat_cnt_q <= beat_cnt_q - BCNT_W'(1);
        end
    end

    always_comb begin
        for (int v = 0; v < CHANNEL_NUM; v++) begin
            take[v] = grant && (arb_idx == CHANNEL_NUM_WIDTH'(v));
            give[v] = credit_valid_i && (credit_vc_i == CHANNEL_NUM_WIDTH'(v));
        end
    end

    // A simultaneous return and consume cancel, so that case never overflows.
    always_comb begin
        credit_bad = credit_valid_i && (int'(credit_vc_i) >= CHANNEL_NUM);
        for (int v = 0; v < CHANNEL_NUM; v++) begin
            credit_d[v] = credit_q[v];
            if (give[v] && !take[v]) begin
                if (credit_q[v] >= 4'(CREDIT_DEPTH)) begin
                    credit_bad = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 4'd1;
                end
            end else if (take[v] && !give[v]) begin
                credit_d[v] = credit_q[v] - 4'd1;
            end
        end
    end

    always_ff @(posedge bus_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < CHANNEL_NUM; v++) begin
                credit_q[v] <= 4'(CREDIT_DEPTH);
            end
            credit_err_q <= 1'b0;
        end else begin
            for (int v = 0; v < CHANNEL_NUM; v++) begin
                credit_q[v] <= credit_d[v];
            end
            if (credit_bad) begin
                credit_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ebi_vc_tx.sv
// Bench for ebi_vc_tx: vector table plus hand-built corner sequences,
// with a queue scoreboard checking every link beat.
module tb_ebi_vc_tx;

    logic        bus_clk = 1'b0;
    logic        rst_n;
    logic [63:0] entry [4];
    logic [3:0]  valid, ready;
    logic        bus_valid;
    logic [7:0]  bus_data;
    logic        credit_valid;
    logic [1:0]  credit_vc;
    logic        credit_err, busy;

    localparam int unsigned LEN5 [5] = '{64, 40, 24, 16, 8};
    logic        rst5_n;
    logic [63:0] entry5 [5];
    logic [4:0]  valid5, ready5;
    logic        bus_valid5;
    logic [7:0]  bus_data5;
    logic        credit_valid5;
    logic [2:0]  credit_vc5;
    logic        credit_err5, busy5;

    always #5 bus_clk = ~bus_clk;

    ebi_vc_tx dut (
        .bus_clk(bus_clk), .rst_n(rst_n),
        .channel_hs_entry_i(entry), .channel_entry_valid_i(valid),
        .channel_push_ready_o(ready), .bus_valid_o(bus_valid), .bus_data_o(bus_data),
        .credit_valid_i(credit_valid), .credit_vc_i(credit_vc),
        .credit_err_o(credit_err), .busy_o(busy)
    );

    ebi_vc_tx #(
        .CHANNEL_NUM(5), .CHANNEL_NUM_WIDTH(3), .CHANNEL_LENGTH_LIST(LEN5)
    ) dut5 (
        .bus_clk(bus_clk), .rst_n(rst5_n),
        .channel_hs_entry_i(entry5), .channel_entry_valid_i(valid5),
        .channel_push_ready_o(ready5), .bus_valid_o(bus_valid5), .bus_data_o(bus_data5),
        .credit_valid_i(credit_valid5), .credit_vc_i(credit_vc5),
        .credit_err_o(credit_err5), .busy_o(busy5)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q [$];
    int unsigned len_tab [4] = '{64, 40, 24, 16};

    typedef struct {
        int          vc;
        logic [63:0] entry;
        bit          ret;
        logic [3:0]  exp_ready;
        int          exp_credit;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic push_msg(input int vc, input logic [63:0] e);
        int unsigned len;
        int          nb;
        logic [63:0] m;
        len = len_tab[vc];
        nb  = int'((len + 7) / 8);
        m   = (len >= 64) ? e : (e & ((64'h1 << len) - 64'h1));
        exp_q.push_back(8'(vc));
        for (int i = 0; i < nb; i++) exp_q.push_back(m[i*8 +: 8]);
    endtask

    task automatic run_to_idle(input string name, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge bus_clk);
            if (busy !== 1'b1) break;
            cyc++;
        end
        check(name, 64'(cyc), 64'(exp_cycles));
    endtask

    // Scoreboard: every valid beat must match the next expected beat in order.
    always @(negedge bus_clk) begin
        if (bus_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got 0x%0h, expected no beat", bus_data);
            end else begin
                check("beat", 64'(bus_data), 64'(exp_q.pop_front()));
            end
        end else begin
            check("idle_data", 64'(bus_data), 64'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ng;
        logic [3:0]  gseq [4];
        logic [63:0] e0, e3;

        tbl[0] = '{2, 64'hDEADBEEF_FFA5C3E1, 1'b0, 4'b0100, 1};
        tbl[1] = '{1, 64'h01234567_89ABCDEF, 1'b0, 4'b0010, 1};
        tbl[2] = '{1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 4'b0010, 0};
        tbl[3] = '{0, 64'h88776655_44332211, 1'b1, 4'b0001, 2};
        tbl[4] = '{3, 64'hFFFFFFFF_FFFFBEEF, 1'b1, 4'b1000, 2};
        tbl[5] = '{2, 64'h00000000_005A0F3C, 1'b1, 4'b0100, 1};

        rst_n = 1'b0; rst5_n = 1'b0;
        for (int v = 0; v < 4; v++) entry[v] = '0;
        for (int v = 0; v < 5; v++) entry5[v] = '0;
        valid = 4'hF; credit_valid = 1'b0; credit_vc = '0;
        valid5 = '0; credit_valid5 = 1'b0; credit_vc5 = '0;

        // Reset state: outputs quiet even with valids high, credits full.
        @(negedge bus_clk);
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_bus_valid", 64'(bus_valid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_err", 64'(credit_err), 64'h0);
        for (int v = 0; v < 4; v++) check("rst_credit", 64'(dut.credit_q[v]), 64'd2);
        step();
        valid = '0; rst_n = 1'b1; rst5_n = 1'b1;

        // VC0 and VC3 held valid: alternate until both run out of credits.
        e0 = 64'hF0E1D2C3_B4A59687;
        e3 = 64'h12345678_9ABC7E55;
        step();
        entry[0] = e0; entry[3] = e3; valid = 4'b1001;
        push_msg(0, e0); push_msg(3, e3); push_msg(0, e0); push_msg(3, e3);
        ng = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge bus_clk);
            if (ready != 4'h0) begin
                if (ng < 4) gseq[ng] = ready;
                ng++;
            end
        end
        check("alt_grant_count", 64'(ng), 64'd4);
        check("alt_g0", 64'(gseq[0]), 64'b0001);
        check("alt_g1", 64'(gseq[1]), 64'b1000);
        check("alt_g2", 64'(gseq[2]), 64'b0001);
        check("alt_g3", 64'(gseq[3]), 64'b1000);
        check("alt_credit0", 64'(dut.credit_q[0]), 64'd0);
        check("alt_credit3", 64'(dut.credit_q[3]), 64'd0);
        check("alt_queue_empty", 64'(exp_q.size()), 64'd0);

        step();
        valid = '0; credit_valid = 1'b1; credit_vc = 2'd0;
        step(); credit_vc = 2'd0;
        step(); credit_vc = 2'd3;
        step(); credit_vc = 2'd3;
        step(); credit_valid = 1'b0;
        @(negedge bus_clk);
        check("refill_credit0", 64'(dut.credit_q[0]), 64'd2);
        check("refill_credit3", 64'(dut.credit_q[3]), 64'd2);
        check("refill_err", 64'(credit_err), 64'h0);

        // Table of single-VC messages.
        for (int i = 0; i < 6; i++) begin
            int w;
            step();
            entry[tbl[i].vc] = tbl[i].entry;
            valid = 4'(1 << tbl[i].vc);
            w = 0;
            @(negedge bus_clk);
            while (ready === 4'h0 && w < 10) begin
                @(negedge bus_clk);
                w++;
            end
            check("tbl_ready_latency", 64'(w), 64'd0);
            check("tbl_ready", 64'(ready), 64'(tbl[i].exp_ready));
            push_msg(tbl[i].vc, tbl[i].entry);
            step();
            valid = '0;
            run_to_idle("tbl_busy_cycles", int'((len_tab[tbl[i].vc] + 7) / 8) + 1);
            if (tbl[i].ret) begin
                step(); credit_valid = 1'b1; credit_vc = 2'(tbl[i].vc);
                step(); credit_valid = 1'b0;
            end
            @(negedge bus_clk);
            check("tbl_credit", 64'(dut.credit_q[tbl[i].vc]), 64'(tbl[i].exp_credit));
        end
        check("tbl_queue_empty", 64'(exp_q.size()), 64'd0);

        // VC1 starved of credits; grant follows the cycle after a return.
        step();
        entry[1] = 64'hFFFFFF12_3456789A; valid = 4'b0010;
        for (int c = 0; c < 3; c++) @(negedge bus_clk);
        check("starved_no_grant", 64'(ready), 64'h0);
        step(); credit_valid = 1'b1; credit_vc = 2'd1;
        @(negedge bus_clk);
        check("return_cycle_no_grant", 64'(ready), 64'h0);
        step(); credit_valid = 1'b0;
        @(negedge bus_clk);
        check("grant_after_return", 64'(ready), 64'b0010);
        push_msg(1, 64'hFFFFFF12_3456789A);
        step(); valid = '0;
        run_to_idle("vc1_busy_cycles", 6);
        check("vc1_credit", 64'(dut.credit_q[1]), 64'd0);

        // Consume and return on VC0 in the same cycle at count 1.
        step();
        entry[0] = 64'h0F1E2D3C_4B5A6978; valid = 4'b0001;
        @(negedge bus_clk);
        check("vc0_first_ready", 64'(ready), 64'b0001);
        push_msg(0, 64'h0F1E2D3C_4B5A6978);
        step(); valid = '0;
        run_to_idle("vc0_busy_cycles", 9);
        check("vc0_credit_one", 64'(dut.credit_q[0]), 64'd1);
        step();
        valid = 4'b0001; credit_valid = 1'b1; credit_vc = 2'd0;
        @(negedge bus_clk);
        check("same_cycle_ready", 64'(ready), 64'b0001);
        push_msg(0, 64'h0F1E2D3C_4B5A6978);
        step(); valid = '0; credit_valid = 1'b0;
        @(negedge bus_clk);
        check("same_cycle_credit", 64'(dut.credit_q[0]), 64'd1);
        run_to_idle("same_cycle_busy", 8);
        check("same_cycle_err", 64'(credit_err), 64'h0);

        // Overflowing return on VC3 is dropped and flagged, stickily.
        step(); credit_valid = 1'b1; credit_vc = 2'd3;
        @(negedge bus_clk);
        check("ovf_err_before", 64'(credit_err), 64'h0);
        step(); credit_valid = 1'b0;
        @(negedge bus_clk);
        check("ovf_err", 64'(credit_err), 64'h1);
        check("ovf_credit3", 64'(dut.credit_q[3]), 64'd2);
        step();
        @(negedge bus_clk);
        check("ovf_err_sticky", 64'(credit_err), 64'h1);

        // Reset during the second payload beat of a VC0 message.
        step();
        entry[0] = 64'h55AA33CC_0FF0C33C; valid = 4'b0001;
        @(negedge bus_clk);
        check("abort_ready", 64'(ready), 64'b0001);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        step(); valid = '0;
        step();
        step();
        rst_n = 1'b0; valid = 4'b1001;
        @(negedge bus_clk);
        check("abort_bus_valid", 64'(bus_valid), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_ready_gated", 64'(ready), 64'h0);
        check("abort_credit0", 64'(dut.credit_q[0]), 64'd2);
        check("abort_err_cleared", 64'(credit_err), 64'h0);
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge bus_clk);
        check("post_reset_grant_vc0", 64'(ready), 64'b0001);
        push_msg(0, 64'h55AA33CC_0FF0C33C);
        step(); valid = '0;
        run_to_idle("post_reset_busy", 9);

        // Five-channel build: VC4 is a real channel, 6 is out of range.
        step();
        entry5[4] = 64'hFFFFFFFF_FFFFFF5A; valid5 = 5'b10000;
        @(negedge bus_clk);
        check("c5_ready", 64'(ready5), 64'b10000);
        step(); valid5 = '0;
        @(negedge bus_clk);
        check("c5_hdr_valid", 64'(bus_valid5), 64'h1);
        check("c5_hdr", 64'(bus_data5), 64'h04);
        step();
        @(negedge bus_clk);
        check("c5_beat", 64'(bus_data5), 64'h5A);
        step();
        @(negedge bus_clk);
        check("c5_done", 64'(bus_valid5), 64'h0);
        check("c5_credit4_used", 64'(dut5.credit_q[4]), 64'd1);
        step(); credit_valid5 = 1'b1; credit_vc5 = 3'd4;
        step(); credit_valid5 = 1'b0;
        @(negedge bus_clk);
        check("c5_vc4_return_ok", 64'(credit_err5), 64'h0);
        check("c5_credit4_back", 64'(dut5.credit_q[4]), 64'd2);
        step(); credit_valid5 = 1'b1; credit_vc5 = 3'd6;
        step(); credit_valid5 = 1'b0;
        @(negedge bus_clk);
        check("c5_range_err", 64'(credit_err5), 64'h1);
        for (int v = 0; v < 5; v++) check("c5_credit_kept", 64'(dut5.credit_q[v]), 64'd2);

        step();
        @(negedge bus_clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
